// File: rtl/relay_station_credit.sv
`default_nettype none
// ============================================================================
// Module      : relay_station_credit
// Description : Credit-based relay station for long stream links. Data and
//               valid travel through LEVEL_FWD register stages into a
//               receiver-side FWFT buffer; each read returns a one-bit credit
//               through LEVEL_BWD register stages to the sender-side credit
//               counter. The buffer covers the full round trip plus DEPTH
//               slack entries, so a continuous stream runs at one word/cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module relay_station_credit #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 2,
    parameter int LEVEL_FWD  = 2,
    parameter int LEVEL_BWD  = 2,
    localparam int BUF_DEPTH = LEVEL_FWD + LEVEL_BWD + 2 + DEPTH,
    localparam int CNT_WIDTH = $clog2(BUF_DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    // sender side
    output logic                  if_full_n,
    input  logic                  if_write_ce,
    input  logic                  if_write,
    input  logic [DATA_WIDTH-1:0] if_din,
    // receiver side
    output logic                  if_empty_n,
    input  logic                  if_read_ce,
    input  logic                  if_read,
    output logic [DATA_WIDTH-1:0] if_dout,
    // status
    output logic [CNT_WIDTH-1:0]  occupancy,
    output logic [CNT_WIDTH-1:0]  credits
);

    // BUF_DEPTH is always >= 2, so the pointer width is at least one bit.
    localparam int                   c_ptr_width = $clog2(BUF_DEPTH);
    localparam logic [c_ptr_width-1:0] c_last_ptr = c_ptr_width'(BUF_DEPTH - 1);
    localparam logic [c_ptr_width-1:0] c_ptr_one  = c_ptr_width'(1);
    localparam logic [CNT_WIDTH-1:0]   c_cnt_one  = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0]   c_cnt_full = CNT_WIDTH'(BUF_DEPTH);

    // ------------------------------------------------------------------
    // Handshake qualifiers
    // ------------------------------------------------------------------
    logic                  w_push;
    logic                  w_pop;
    logic                  w_credit_ret;
    logic                  w_buf_wr;
    logic [DATA_WIDTH-1:0] w_buf_din;

    logic [CNT_WIDTH-1:0]   r_credits;
    logic [CNT_WIDTH-1:0]   r_occ;
    logic [c_ptr_width-1:0] r_wptr;
    logic [c_ptr_width-1:0] r_rptr;
    logic [DATA_WIDTH-1:0]  r_mem [BUF_DEPTH];

    // Full flag comes straight from the counter register, never from if_write.
    assign if_full_n  = (r_credits != '0);
    assign if_empty_n = (r_occ != '0);
    assign w_push     = if_write & if_write_ce & if_full_n;
    assign w_pop      = if_read & if_read_ce & if_empty_n;

    // Circular increment that tolerates a non-power-of-two depth.
    function automatic logic [c_ptr_width-1:0] f_ptr_inc(input logic [c_ptr_width-1:0] p);
        return (p == c_last_ptr) ? '0 : p + c_ptr_one;
    endfunction

    // ------------------------------------------------------------------
    // Sender-side credit counter
    // ------------------------------------------------------------------
    // Consume one credit per push, regain one per returned token; both at once cancel.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_credits <= c_cnt_full;
        end else if (w_push && !w_credit_ret) begin
            r_credits <= r_credits - c_cnt_one;
        end else if (!w_push && w_credit_ret) begin
            r_credits <= r_credits + c_cnt_one;
        end
    end

    // ------------------------------------------------------------------
    // Forward data pipe
    // ------------------------------------------------------------------
    generate
        if (LEVEL_FWD == 0) begin : g_fwd_bypass
            assign w_buf_wr  = w_push;
            assign w_buf_din = if_din;
        end else begin : g_fwd_pipe
            logic [LEVEL_FWD-1:0]  r_vld;
            logic [DATA_WIDTH-1:0] r_data [LEVEL_FWD];

            // Valid bits shift every cycle; the receiver always has room, so no stall.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_vld <= '0;
                end else begin
                    r_vld[0] <= w_push;
                    for (int k = 1; k < LEVEL_FWD; k++) begin
                        r_vld[k] <= r_vld[k-1];
                    end
                end
            end

            // Payload follows its valid bit; the first stage only loads on a push.
            always_ff @(posedge clk) begin
                if (w_push) begin
                    r_data[0] <= if_din;
                end
                for (int k = 1; k < LEVEL_FWD; k++) begin
                    r_data[k] <= r_data[k-1];
                end
            end

            assign w_buf_wr  = r_vld[LEVEL_FWD-1];
            assign w_buf_din = r_data[LEVEL_FWD-1];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Receiver FWFT buffer
    // ------------------------------------------------------------------
    // Storage array has no reset so it can map onto distributed RAM / SRLs.
    always_ff @(posedge clk) begin
        if (w_buf_wr) begin
            r_mem[r_wptr] <= w_buf_din;
        end
    end

    // Write pointer advances on every arriving word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wptr <= '0;
        end else if (w_buf_wr) begin
            r_wptr <= f_ptr_inc(r_wptr);
        end
    end

    // Read pointer advances on every accepted read.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rptr <= '0;
        end else if (w_pop) begin
            r_rptr <= f_ptr_inc(r_rptr);
        end
    end

    // Occupancy tracks arrivals minus reads; a simultaneous pair leaves it unchanged.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_occ <= '0;
        end else if (w_buf_wr && !w_pop) begin
            r_occ <= r_occ + c_cnt_one;
        end else if (!w_buf_wr && w_pop) begin
            r_occ <= r_occ - c_cnt_one;
        end
    end

    assign if_dout   = r_mem[r_rptr];
    assign occupancy = r_occ;
    assign credits   = r_credits;

    // ------------------------------------------------------------------
    // Credit-return pipe
    // ------------------------------------------------------------------
    generate
        if (LEVEL_BWD == 0) begin : g_bwd_bypass
            assign w_credit_ret = w_pop;
        end else begin : g_bwd_pipe
            logic [LEVEL_BWD-1:0] r_tok;

            // One-bit tokens shift back to the sender; reset drops any in flight.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_tok <= '0;
                end else begin
                    r_tok[0] <= w_pop;
                    for (int k = 1; k < LEVEL_BWD; k++) begin
                        r_tok[k] <= r_tok[k-1];
                    end
                end
            end

            assign w_credit_ret = r_tok[LEVEL_BWD-1];
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_relay_station_credit.sv
`default_nettype none
// ============================================================================
// Module      : tb_relay_station_credit
// Description : Self-checking bench for relay_station_credit. Three instances
//               (default, all-zero levels, DEPTH=1/FWD=3/BWD=1) are checked
//               every cycle against a cumulative push/pop latency model and
//               per-instance data scoreboards, plus a directed vector table.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_relay_station_credit;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    // instance A: defaults (BUF_DEPTH 8)
    logic        a_wr, a_wce, a_rd, a_rce, a_fn, a_en;
    logic [31:0] a_din, a_dout;
    logic [3:0]  a_occ, a_cred;
    // instance B: all levels zero (BUF_DEPTH 2)
    logic        b_wr, b_wce, b_rd, b_rce, b_fn, b_en;
    logic [31:0] b_din, b_dout;
    logic [1:0]  b_occ, b_cred;
    // instance C: DEPTH 1, FWD 3, BWD 1 (BUF_DEPTH 7)
    logic        c_wr, c_wce, c_rd, c_rce, c_fn, c_en;
    logic [31:0] c_din, c_dout;
    logic [2:0]  c_occ, c_cred;

    relay_station_credit #(.DATA_WIDTH(32), .DEPTH(2), .LEVEL_FWD(2), .LEVEL_BWD(2)) u_a (
        .clk(clk), .reset(reset),
        .if_full_n(a_fn), .if_write_ce(a_wce), .if_write(a_wr), .if_din(a_din),
        .if_empty_n(a_en), .if_read_ce(a_rce), .if_read(a_rd), .if_dout(a_dout),
        .occupancy(a_occ), .credits(a_cred)
    );
    relay_station_credit #(.DATA_WIDTH(32), .DEPTH(0), .LEVEL_FWD(0), .LEVEL_BWD(0)) u_b (
        .clk(clk), .reset(reset),
        .if_full_n(b_fn), .if_write_ce(b_wce), .if_write(b_wr), .if_din(b_din),
        .if_empty_n(b_en), .if_read_ce(b_rce), .if_read(b_rd), .if_dout(b_dout),
        .occupancy(b_occ), .credits(b_cred)
    );
    relay_station_credit #(.DATA_WIDTH(32), .DEPTH(1), .LEVEL_FWD(3), .LEVEL_BWD(1)) u_c (
        .clk(clk), .reset(reset),
        .if_full_n(c_fn), .if_write_ce(c_wce), .if_write(c_wr), .if_din(c_din),
        .if_empty_n(c_en), .if_read_ce(c_rce), .if_read(c_rd), .if_dout(c_dout),
        .occupancy(c_occ), .credits(c_cred)
    );

    int n_checks = 0;
    int n_fail   = 0;

    function automatic void chk(input string nm, input int inst, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s inst=%0d t=%0t actual=%0h required=%0h", nm, inst, $time, act, exp);
        end
    endfunction

    function automatic int lf(input int i);
        return (i == 0) ? 2 : (i == 1) ? 0 : 3;
    endfunction
    function automatic int lb(input int i);
        return (i == 0) ? 2 : (i == 1) ? 0 : 1;
    endfunction
    function automatic int bd(input int i);
        return (i == 0) ? 8 : (i == 1) ? 2 : 7;
    endfunction

    // Cumulative counts: cp[i][c] = pushes accepted in cycles 0..c-1 since reset release.
    localparam int MAXC = 16384;
    int   cp  [3][MAXC];
    int   cpo [3][MAXC];
    int   cyc = 0;
    logic mon_en = 1'b0;

    logic [31:0] qa[$];
    logic [31:0] qb[$];
    logic [31:0] qc[$];

    function automatic void sb_push(input int i, input logic [31:0] d);
        if (i == 0) qa.push_back(d);
        else if (i == 1) qb.push_back(d);
        else qc.push_back(d);
    endfunction

    function automatic int sb_size(input int i);
        return (i == 0) ? qa.size() : (i == 1) ? qb.size() : qc.size();
    endfunction

    function automatic logic [31:0] sb_pop(input int i);
        if (i == 0) return qa.pop_front();
        else if (i == 1) return qb.pop_front();
        else return qc.pop_front();
    endfunction

    // Per-cycle model step: expected status from latency arithmetic, data from scoreboard.
    function automatic void model_cycle(input int i, input logic fn, input logic en, input int occ, input int cred,
                                        input logic [31:0] dout, input logic wr, input logic wce,
                                        input logic [31:0] din, input logic rd, input logic rce);
        int   c, eo, ec;
        logic push, pop;
        c  = cyc;
        eo = cp[i][(c > lf(i)) ? c - lf(i) : 0] - cpo[i][c];
        ec = bd(i) - cp[i][c] + cpo[i][(c > lb(i)) ? c - lb(i) : 0];
        chk("occupancy", i, 64'(occ), 64'(eo));
        chk("credits", i, 64'(cred), 64'(ec));
        chk("full_n", i, 64'(fn), 64'(ec != 0));
        chk("empty_n", i, 64'(en), 64'(eo != 0));
        chk("bound", i, 64'(occ <= bd(i) && cred <= bd(i)), 64'(1));
        push = wr & wce & (ec != 0);
        pop  = rd & rce & (eo != 0);
        if (pop && sb_size(i) > 0) chk("dout", i, 64'(dout), 64'(sb_pop(i)));
        if (push) sb_push(i, din);
        cp[i][c+1]  = cp[i][c] + int'(push);
        cpo[i][c+1] = cpo[i][c] + int'(pop);
    endfunction

    // Monitor samples all instances on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (mon_en && cyc < MAXC - 1) begin
            model_cycle(0, a_fn, a_en, int'(a_occ), int'(a_cred), a_dout, a_wr, a_wce, a_din, a_rd, a_rce);
            model_cycle(1, b_fn, b_en, int'(b_occ), int'(b_cred), b_dout, b_wr, b_wce, b_din, b_rd, b_rce);
            model_cycle(2, c_fn, c_en, int'(c_occ), int'(c_cred), c_dout, c_wr, c_wce, c_din, c_rd, c_rce);
            cyc++;
        end
    end

    typedef struct {
        logic        wr, wce;
        logic [31:0] din;
        logic        rd, rce;
        logic        fn, en;
        int          occ, cred;
    } vec_t;
    vec_t tbl[$];

    function automatic void addv(input logic wr, input logic wce, input logic [31:0] din, input logic rd,
                                 input logic rce, input logic fn, input logic en, input int occ, input int cred);
        vec_t v;
        v.wr = wr; v.wce = wce; v.din = din; v.rd = rd; v.rce = rce;
        v.fn = fn; v.en = en; v.occ = occ; v.cred = cred;
        tbl.push_back(v);
    endfunction

    task automatic zero_inputs();
        a_wr = 0; a_wce = 0; a_rd = 0; a_rce = 0; a_din = '0;
        b_wr = 0; b_wce = 0; b_rd = 0; b_rce = 0; b_din = '0;
        c_wr = 0; c_wce = 0; c_rd = 0; c_rce = 0; c_din = '0;
    endtask

    // Holds reset for two edges and releases it just after a rising edge (cycle 0 starts).
    task automatic do_reset();
        mon_en = 1'b0;
        reset  = 1'b1;
        zero_inputs();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        qa.delete(); qb.delete(); qc.delete();
        for (int i = 0; i < 3; i++) begin
            cp[i][0]  = 0;
            cpo[i][0] = 0;
        end
        cyc    = 0;
        mon_en = 1'b1;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog inst=0 actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int pops;
        zero_inputs();

        // wr wce din rd rce | full_n empty_n occ cred
        for (int k = 0; k < 8; k++)
            addv(1, 1, 32'(k), 0, 0, 1, (k >= 3), (k >= 3) ? k - 2 : 0, 8 - k);
        addv(1, 1, 32'd8, 0, 0, 0, 1, 6, 0);
        addv(1, 1, 32'd9, 0, 0, 0, 1, 7, 0);
        addv(0, 0, 32'd0, 0, 0, 0, 1, 8, 0);
        addv(0, 0, 32'd0, 0, 0, 0, 1, 8, 0);
        addv(0, 0, 32'd0, 1, 1, 0, 1, 8, 0);  // single pop from full
        addv(0, 0, 32'd0, 0, 0, 0, 1, 7, 0);
        addv(0, 0, 32'd0, 0, 0, 0, 1, 7, 0);
        addv(0, 0, 32'd0, 0, 0, 1, 1, 7, 1);  // credit back three cycles later
        addv(0, 0, 32'd0, 1, 1, 1, 1, 7, 1);
        addv(0, 0, 32'd0, 1, 1, 1, 1, 6, 1);
        addv(0, 0, 32'd0, 1, 1, 1, 1, 5, 1);
        addv(0, 0, 32'd0, 1, 1, 1, 1, 4, 2);
        addv(0, 0, 32'd0, 1, 1, 1, 1, 3, 3);
        addv(0, 0, 32'd0, 1, 1, 1, 1, 2, 4);
        addv(0, 0, 32'd0, 1, 1, 1, 1, 1, 5);
        addv(0, 0, 32'd0, 0, 0, 1, 0, 0, 6);
        addv(0, 0, 32'd0, 0, 0, 1, 0, 0, 7);
        addv(0, 0, 32'd0, 0, 0, 1, 0, 0, 8);
        addv(0, 0, 32'd0, 0, 0, 1, 0, 0, 8);
        addv(1, 0, 32'h55, 0, 0, 1, 0, 0, 8); // write without ce is ignored
        addv(1, 1, 32'h77, 0, 0, 1, 0, 0, 8);
        addv(0, 0, 32'd0, 0, 0, 1, 0, 0, 7);
        addv(0, 0, 32'd0, 0, 0, 1, 0, 0, 7);
        addv(0, 0, 32'd0, 1, 0, 1, 1, 1, 7);  // read without ce is ignored
        addv(0, 0, 32'd0, 1, 1, 1, 1, 1, 7);
        addv(0, 0, 32'd0, 1, 1, 1, 0, 0, 7);  // read while empty is ignored
        addv(0, 0, 32'd0, 0, 0, 1, 0, 0, 7);
        addv(0, 0, 32'd0, 0, 0, 1, 0, 0, 8);

        do_reset();

        // directed vector table on instance A
        foreach (tbl[r]) begin
            a_wr = tbl[r].wr; a_wce = tbl[r].wce; a_din = tbl[r].din;
            a_rd = tbl[r].rd; a_rce = tbl[r].rce;
            @(negedge clk);
            chk("tbl_full_n", r, 64'(a_fn), 64'(tbl[r].fn));
            chk("tbl_empty_n", r, 64'(a_en), 64'(tbl[r].en));
            chk("tbl_occupancy", r, 64'(a_occ), 64'(tbl[r].occ));
            chk("tbl_credits", r, 64'(a_cred), 64'(tbl[r].cred));
            next_cycle();
        end
        zero_inputs();

        // continuous write + continuous read: 1000 words at full rate
        pops = 0;
        for (int k = 0; k < 1008; k++) begin
            a_wr = (k < 1000); a_wce = 1'b1; a_din = 32'(1000 + k);
            a_rd = 1'b1; a_rce = 1'b1;
            @(negedge clk);
            if (a_rd && a_rce && a_en) pops++;
            if (k < 1000) chk("stream_full_n", 0, 64'(a_fn), 64'(1));
            next_cycle();
        end
        chk("stream_pops", 0, 64'(pops), 64'(1000));
        zero_inputs();

        // reset asserted asynchronously with words in flight
        for (int k = 0; k < 5; k++) begin
            a_wr = 1'b1; a_wce = 1'b1; a_din = 32'(100 + k);
            next_cycle();
        end
        a_wr   = 1'b0;
        mon_en = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        chk("async_rst_full_n", 0, 64'(a_fn), 64'(1));
        chk("async_rst_empty_n", 0, 64'(a_en), 64'(0));
        chk("async_rst_credits", 0, 64'(a_cred), 64'(8));
        chk("async_rst_occupancy", 0, 64'(a_occ), 64'(0));
        do_reset();

        a_wr = 1'b1; a_wce = 1'b1; a_din = 32'hA5;
        next_cycle();
        a_wr = 1'b0;
        next_cycle();
        next_cycle();
        a_rd = 1'b1; a_rce = 1'b1;
        @(negedge clk);
        chk("post_rst_empty_n", 0, 64'(a_en), 64'(1));
        chk("post_rst_dout", 0, 64'(a_dout), 64'hA5);
        next_cycle();
        zero_inputs();

        // random ce/read/write on the zero-level and odd-depth instances
        for (int k = 0; k < 10000; k++) begin
            b_wr  = ($urandom_range(0, 3) != 0);
            b_wce = ($urandom_range(0, 3) != 0);
            b_din = $urandom;
            b_rd  = ($urandom_range(0, 1) != 0);
            b_rce = ($urandom_range(0, 3) != 0);
            c_wr  = ($urandom_range(0, 7) != 0);
            c_wce = 1'b1;
            c_din = $urandom;
            c_rd  = ($urandom_range(0, 9) < 6);
            c_rce = ($urandom_range(0, 4) != 0);
            next_cycle();
        end
        zero_inputs();
        b_rd = 1'b1; b_rce = 1'b1;
        c_rd = 1'b1; c_rce = 1'b1;
        repeat (40) next_cycle();
        zero_inputs();
        @(negedge clk);
        chk("drain_sb_a", 0, 64'(qa.size()), 64'(0));
        chk("drain_sb_b", 1, 64'(qb.size()), 64'(0));
        chk("drain_sb_c", 2, 64'(qc.size()), 64'(0));
        chk("drain_credits_b", 1, 64'(b_cred), 64'(2));
        chk("drain_credits_c", 2, 64'(c_cred), 64'(7));
        chk("drain_empty_c", 2, 64'(c_en), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
